// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the MEM stage and the word-addressed mem_ctrl memory.
// Sub-word loads are extracted and extended; sub-word stores are read-modify-write.
module lsu_mem_adapter #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-3:0] mem_waddr,
    output logic [ADDR_W-3:0] mem_raddr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ready,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    // Request fields still needed after the memory access starts.
    typedef struct packed {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lane;
        logic [15:0] wdata;
    } req_t;

    state_t            state_q;
    req_t              req_q;
    logic              req_err_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [WIDTH-1:0]  load_d;
    logic [WIDTH-1:0]  merge_d;
    logic [7:0]        rd_byte_c;
    logic [15:0]       rd_half_c;

    assign req_idx_c = req_addr[ADDR_W-1:2];

    // Illegal size or misaligned address for the requested size.
    always_comb begin
        req_err_c = 1'b0;
        case (req_size)
            SZ_BYTE: req_err_c = 1'b0;
            SZ_HALF: req_err_c = req_addr[0];
            SZ_WORD: req_err_c = |req_addr[1:0];
            default: req_err_c = 1'b1;
        endcase
    end

    // Lane extraction and extension of the word returned by memory.
    always_comb begin
        rd_byte_c = mem_rdata[{req_q.lane, 3'b000} +: 8];
        rd_half_c = mem_rdata[{req_q.lane[1], 4'b0000} +: 16];
        load_d    = mem_rdata;
        case (req_q.size)
            SZ_BYTE: load_d = req_q.uns ? {{(WIDTH-8){1'b0}}, rd_byte_c}
                                        : {{(WIDTH-8){rd_byte_c[7]}}, rd_byte_c};
            SZ_HALF: load_d = req_q.uns ? {{(WIDTH-16){1'b0}}, rd_half_c}
                                        : {{(WIDTH-16){rd_half_c[15]}}, rd_half_c};
            default: load_d = mem_rdata;
        endcase
    end

    // Old word with only the addressed lane(s) replaced by the store data.
    always_comb begin
        merge_d = mem_rdata;
        if (req_q.size == SZ_BYTE) begin
            merge_d[{req_q.lane, 3'b000} +: 8] = req_q.wdata[7:0];
        end else begin
            merge_d[{req_q.lane[1], 4'b0000} +: 16] = req_q.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_waddr  <= '0;
            mem_raddr  <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        req_q.size  <= req_size;
                        req_q.uns   <= req_unsigned;
                        req_q.lane  <= req_addr[1:0];
                        req_q.wdata <= req_wdata[15:0];
                        if (req_err_c) begin
                            state_q    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_we) begin
                            state_q   <= S_RD;
                            mem_re    <= 1'b1;
                            mem_raddr <= req_idx_c;
                        end else if (req_size == SZ_WORD) begin
                            state_q   <= S_WR;
                            mem_we    <= 1'b1;
                            mem_waddr <= req_idx_c;
                            mem_wdata <= req_wdata;
                        end else begin
                            state_q   <= S_RMW_RD;
                            mem_re    <= 1'b1;
                            mem_raddr <= req_idx_c;
                            mem_waddr <= req_idx_c;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        state_q    <= S_RESP;
                        mem_re     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_d;
                    end
                end
                S_RMW_RD: begin
                    if (mem_ready) begin
                        state_q   <= S_RMW_WR;
                        mem_re    <= 1'b0;
                        mem_wdata <= merge_d;
                    end
                end
                S_RMW_WR: begin
                    // First cycle here is the idle gap between the read and the write.
                    if (!mem_we) begin
                        mem_we <= 1'b1;
                    end else if (mem_ready) begin
                        state_q    <= S_RESP;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        state_q    <= S_RESP;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                S_RESP: begin
                    state_q    <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_re    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Scoreboard bench for lsu_mem_adapter: a memory responder with random ready,
// a byte-level reference model computing expected responses, and a protocol monitor.
module tb_lsu_mem_adapter;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned IW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_we;
    logic          mem_re;
    logic [IW-1:0] mem_waddr;
    logic [IW-1:0] mem_raddr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_adapter #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_we(mem_we), .mem_re(mem_re),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rd;
        int          wr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_array [DEPTH];
    logic [31:0] ref_mem   [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_n  = 0;
    bit          block_we = 1'b0;

    logic [31:0]   last_rdata = '0;
    logic          last_err   = 1'b0;
    logic [IW-1:0] last_waddr = '0;
    logic [31:0]   last_wdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model standing in for mem_ctrl.
    assign mem_rdata = mem_array[mem_raddr];

    always @(posedge clk) begin
        if (!rstn && mem_we && mem_ready) mem_array[mem_waddr] <= mem_wdata;
    end

    always @(posedge clk) begin
        #1;
        if (stall_n > 0) begin
            mem_ready = 1'b0;
            if (mem_re || mem_we) stall_n--;
        end else if (block_we && mem_we) begin
            mem_ready = 1'b0;
        end else begin
            mem_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Protocol monitor and scoreboard checker.
    logic          re_prev = 1'b0, we_prev = 1'b0, resp_prev = 1'b0, done_prev = 1'b0;
    logic [IW-1:0] raddr_prev = '0, waddr_prev = '0;
    logic [31:0]   wdata_prev = '0;
    int            rd_cnt = 0, wr_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            re_prev = 1'b0; we_prev = 1'b0; resp_prev = 1'b0; done_prev = 1'b0;
            rd_cnt = 0; wr_cnt = 0;
        end else begin
            if (mem_re && mem_we) chk("we_re_exclusive", 32'(mem_re & mem_we), 32'd0);
            if (mem_re && re_prev) chk("raddr_stable", 32'(mem_raddr), 32'(raddr_prev));
            if (mem_we && we_prev) begin
                chk("waddr_stable", 32'(mem_waddr), 32'(waddr_prev));
                chk("wdata_stable", mem_wdata, wdata_prev);
            end
            if (mem_re && !re_prev) begin
                chk("gap_before_read", 32'(we_prev), 32'd0);
                rd_cnt++;
            end
            if (mem_we && !we_prev) begin
                chk("gap_before_write", 32'(re_prev), 32'd0);
                wr_cnt++;
            end
            if (mem_we && mem_ready) begin
                last_waddr = mem_waddr;
                last_wdata = mem_wdata;
            end
            if (resp_valid) begin
                if (resp_prev) chk("resp_single_cycle", 32'(resp_prev), 32'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("mem_reads", 32'(rd_cnt), 32'(e.rd));
                    chk("mem_writes", 32'(wr_cnt), 32'(e.wr));
                    if (!e.err) chk("resp_latency", 32'(done_prev), 32'd1);
                end
                last_rdata = resp_rdata;
                last_err   = resp_err;
                rd_cnt = 0;
                wr_cnt = 0;
            end
            done_prev  = (mem_re || mem_we) && mem_ready;
            re_prev    = mem_re;
            we_prev    = mem_we;
            resp_prev  = resp_valid;
            raddr_prev = mem_raddr;
            waddr_prev = mem_waddr;
            wdata_prev = mem_wdata;
        end
    end

    // Issue one request (caller sits at a negedge); expected response comes from the byte-level model.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [AW-1:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        int          sh;
        logic [31:0] w, v, mask;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        w  = ref_mem[a[AW-1:2]];
        sh = int'(a[1:0]) * 8;
        e.rdata = '0; e.err = 1'b0; e.rd = 0; e.wr = 0;
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
            e.err = 1'b1;
        end else if (!we) begin
            e.rd = 1;
            if (sz == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e.rdata = v;
        end else if (sz == 2'd2) begin
            e.wr = 1;
            ref_mem[a[AW-1:2]] = wd;
        end else begin
            e.rd = 1;
            e.wr = 1;
            mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
            ref_mem[a[AW-1:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() > 0) chk("resp_timeout", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]    sz;
        logic [AW-1:0] a;
        int            n;
        for (int i = 0; i < DEPTH; i++) begin
            mem_array[i] = $urandom;
            ref_mem[i]   = mem_array[i];
        end
        mem_ready = 1'b0;
        rstn = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 6'h08; req_wdata = '0;

        // Reset held with a pending request.
        repeat (3) begin
            @(negedge clk);
            chk("reset_mem_we", 32'(mem_we), 32'd0);
            chk("reset_mem_re", 32'(mem_re), 32'd0);
            chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        end
        req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 6'h08, 32'hDEAD_BEEF);
        wait_idle();
        chk("word_store_waddr", 32'(last_waddr), 32'd2);
        chk("word_store_wdata", last_wdata, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
        wait_idle();
        chk("word_load_data", last_rdata, 32'hDEAD_BEEF);
        chk("word_load_err", 32'(last_err), 32'd0);

        do_req(1'b1, 2'd2, 1'b0, 6'h08, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 6'h09, 32'h0000_005A);
        wait_idle();
        chk("rmw_waddr", 32'(last_waddr), 32'd2);
        chk("rmw_wdata", last_wdata, 32'h1122_5A44);
        do_req(1'b1, 2'd0, 1'b0, 6'h0B, 32'h0000_0080);
        do_req(1'b0, 2'd0, 1'b0, 6'h0B, 32'h0);
        wait_idle();
        chk("byte_load_signed", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 6'h0B, 32'h0);
        wait_idle();
        chk("byte_load_unsigned", last_rdata, 32'h0000_0080);

        do_req(1'b1, 2'd2, 1'b0, 6'h04, 32'h8001_1234);
        do_req(1'b0, 2'd1, 1'b0, 6'h06, 32'h0);
        wait_idle();
        chk("half_load_signed", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b0, 6'h05, 32'h0);
        wait_idle();
        chk("half_misaligned_err", 32'(last_err), 32'd1);
        chk("half_misaligned_data", last_rdata, 32'd0);

        // Five stalled cycles during a load.
        stall_n = 5;
        do_req(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
        wait_idle();
        chk("stalled_load_data", last_rdata, 32'h8022_5A44);
        chk("stall_consumed", 32'(stall_n), 32'd0);

        // Reset while the RMW write is waiting for mem_ready.
        block_we = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 6'h11; req_wdata = 32'h0000_00C3;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rmw_wr_reached", 32'(mem_we), 32'd1);
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_re", 32'(mem_re), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        rstn = 1'b0;
        block_we = 1'b0;
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
        wait_idle();

        // Randomized traffic, mostly aligned.
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        wait_idle();

        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("final_mem[%0d]", i), mem_array[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
